uart_trade_reporter: RTL
========================

# uart_trade_reporter

Serializes trading decisions back to the host over the same 8N1 UART link the price feed arrives on, providing the transmit path that complements the price receiver. Each accepted decision event (side + price byte) is queued in a small FIFO and sent as a 4-byte ASCII message: side letter, two uppercase hex digits of the price, newline. It sits beside the threshold comparator and is fed one event per comparator decision.

## Interface

- CLKS_PER_BIT, default 868: clock cycles per UART bit (100 MHz / 115200 baud); legal range ≥ 2.
- FIFO_DEPTH, default 4: event queue depth; power of two, ≥ 2.

- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- evt_valid  in  1  decision event present this cycle.
- evt_side  in  2  2'b01 buy, 2'b10 sell, 2'b00 hold, 2'b11 invalid.
- evt_price  in  8  price byte that produced the decision.
- evt_ready  out  1  FIFO not full; event accepted when evt_valid && evt_ready.
- tx  out  1  UART serial output, idles high.
- busy  out  1  FIFO non-empty or message in progress.
- overflow  out  1  sticky: set when evt_valid && !evt_ready; cleared only by rst.

## Operation

- FIFO: stores {side, price}, FIFO_DEPTH entries. Pointers wrap modulo FIFO_DEPTH; count has width log2(FIFO_DEPTH)+1.
- evt_ready = (count != FIFO_DEPTH), derived from the registered count. A push while full is rejected even if a pop occurs in the same cycle. Push and pop in the same cycle when not full: count unchanged.
- Rejected events are dropped (no partial write) and set overflow.
- Message encoding, bytes sent in order:
  - byte 0: 0x42 'B' (01), 0x53 'S' (10), 0x48 'H' (00), 0x58 'X' (11).
  - byte 1: ASCII of price[7:4]; byte 2: ASCII of price[3:0]. Nibble 0–9 maps to 0x30–0x39, A–F maps to 0x41–0x46.
  - byte 3: 0x0A.
- Message sequencer FSM:
  - MSG_IDLE goes to MSG_SEND when the FIFO is non-empty; pops the head entry into a message register.
  - MSG_SEND walks byte index 0..3, handing each byte to the bit engine as it becomes free.
  - After byte 3 completes, goes to MSG_SEND with the next entry if the FIFO is non-empty, otherwise to MSG_IDLE.
- Bit engine FSM:
  - TX_IDLE (tx=1), then TX_START (tx=0), then TX_DATA (8 bits, LSB first), then TX_STOP (tx=1), then back to TX_IDLE or TX_START.
  - Each bit lasts exactly CLKS_PER_BIT cycles, timed by a baud counter that runs 0..CLKS_PER_BIT-1.
  - A data bit index of 0..7 selects the bit.
- The FIFO entry is popped when its message begins. The FIFO may therefore accept up to FIFO_DEPTH new events while a message is on the wire.
- tx is registered; it has no combinational path from inputs.

## Timing

- Reset values: tx=1, evt_ready=1, busy=0, overflow=0. FIFO is empty, both FSMs are idle, and all counters are 0.
- rst asserted mid-frame: tx=1 from the cycle after the reset edge. The in-flight byte, the message and the FIFO contents are discarded. No resumption after reset.
- Latency: event accepted at edge E while both FSMs are idle. tx goes low at edge E+2. busy is 1 from E+1 until tx has returned to idle after the last stop bit.
- One byte takes exactly 10×CLKS_PER_BIT cycles.
- Within a message, the start bit of byte k+1 immediately follows the stop bit of byte k (0 idle cycles).
- Between back-to-back messages (FIFO non-empty at the end of byte 3): at most 2 idle-high cycles.
- A message is exactly 40×CLKS_PER_BIT cycles, plus the inter-message gap.
- evt_ready deasserts the cycle after the FIFO_DEPTH-th accepted push with no pop. It reasserts the cycle after the next pop.
- overflow rises the cycle after the first rejected push and holds until rst.

## Test plan

- Use CLKS_PER_BIT=4, FIFO_DEPTH=4 for all scenarios.
- Single buy: side=01, price=0x7F, bus idle → tx low at E+2. Decoded bytes are 0x42, 0x37, 0x46, 0x0A, each start/stop bit 4 cycles wide. busy falls after 160 cycles.
- Encoding sweep: sell 0x00, hold 0xA9, invalid 0xFF, pushed back-to-back → messages 'S','0','0',LF / 'H','A','9',LF / 'X','F','F',LF. Gap between messages ≤ 2 cycles.
- Full/overflow: 6 pushes on consecutive cycles → first 5 accepted (1 popped into flight, 4 queued). evt_ready=0 after the 5th push. The 6th is rejected and overflow=1. Exactly 5 messages are transmitted.
- Simultaneous push/pop at full: FIFO full while a message completes, evt_valid held → push rejected in the pop cycle. Accepted the next cycle when evt_ready=1.
- Reset mid-byte: rst pulsed during bit 3 of byte 1 → tx=1 the next cycle. busy=0, evt_ready=1, overflow=0. No further traffic until a new event, which then transmits cleanly.

Source files
------------

// File: rtl/uart_trade_reporter_if.sv
// Decision-event handshake between the threshold comparator and the trade reporter.
interface uart_trade_reporter_if;
  logic       evt_valid;
  logic [1:0] evt_side;
  logic [7:0] evt_price;
  logic       evt_ready;

  modport master (
    output evt_valid,
    output evt_side,
    output evt_price,
    input  evt_ready
  );

  modport slave (
    input  evt_valid,
    input  evt_side,
    input  evt_price,
    output evt_ready
  );
endinterface

// File: rtl/uart_trade_reporter.sv
// UART trade reporter: queues {side, price} decision events and sends each one as a
// 4-byte ASCII message (side letter, two hex digits, LF) over an 8N1 serial line.
module uart_trade_reporter #(
  parameter int unsigned CLKS_PER_BIT = 868,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  uart_trade_reporter_if.slave evt,
  output logic                 tx,
  output logic                 busy,
  output logic                 overflow
);

  localparam int unsigned PtrW  = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW  = PtrW + 1;
  localparam int unsigned BaudW = $clog2(CLKS_PER_BIT);

  localparam logic [CntW-1:0]  CntFull  = CntW'(FIFO_DEPTH);
  localparam logic [BaudW-1:0] BaudLast = BaudW'(CLKS_PER_BIT - 1);

  // Message sequencer states
  localparam logic [0:0] MSG_IDLE = 1'b0;
  localparam logic [0:0] MSG_SEND = 1'b1;

  // Bit engine states
  localparam logic [1:0] TX_IDLE  = 2'b00;
  localparam logic [1:0] TX_START = 2'b01;
  localparam logic [1:0] TX_DATA  = 2'b10;
  localparam logic [1:0] TX_STOP  = 2'b11;

  // ---------------------------------------------------------------------------
  // Event FIFO
  // ---------------------------------------------------------------------------
  logic [9:0]      fifo_mem [FIFO_DEPTH];
  logic [PtrW-1:0] wr_ptr_q;
  logic [PtrW-1:0] rd_ptr_q;
  logic [CntW-1:0] count_q;
  logic            overflow_q;
  logic            evt_ready_int;
  logic            fifo_empty;
  logic            fifo_push;
  logic            fifo_pop;
  logic [9:0]      fifo_head;

  // Ready comes only from the registered count, so a pop never frees a slot in its own cycle.
  assign evt_ready_int = (count_q != CntFull);
  assign evt.evt_ready = evt_ready_int;
  assign fifo_empty    = (count_q == '0);
  assign fifo_push     = evt.evt_valid && evt_ready_int;
  assign fifo_head     = fifo_mem[rd_ptr_q];

  // Pointer, occupancy and sticky overflow bookkeeping
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (fifo_push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (fifo_pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      if (fifo_push && !fifo_pop) begin
        count_q <= count_q + CntW'(1);
      end else if (!fifo_push && fifo_pop) begin
        count_q <= count_q - CntW'(1);
      end
      if (evt.evt_valid && !evt_ready_int) overflow_q <= 1'b1;
    end
  end

  // Storage array; contents are don't-care while the entry is unoccupied
  always_ff @(posedge clk) begin
    if (fifo_push) fifo_mem[wr_ptr_q] <= {evt.evt_side, evt.evt_price};
  end

  // ---------------------------------------------------------------------------
  // Message sequencer
  // ---------------------------------------------------------------------------
  logic [0:0] msg_state_q, msg_state_d;
  logic [2:0] byte_idx_q, byte_idx_d;   // bytes handed to the bit engine; 4 = all handed
  logic [1:0] msg_side_q, msg_side_d;
  logic [7:0] msg_price_q, msg_price_d;
  logic [7:0] cur_byte;
  logic       tx_free;
  logic       tx_load;

  function automatic logic [7:0] hex_ascii(input logic [3:0] nib);
    if (nib < 4'd10) return 8'h30 + {4'h0, nib};
    else             return 8'h37 + {4'h0, nib};
  endfunction

  function automatic logic [7:0] side_ascii(input logic [1:0] side);
    case (side)
      2'b01:   return 8'h42;  // B
      2'b10:   return 8'h53;  // S
      2'b00:   return 8'h48;  // H
      default: return 8'h58;  // X
    endcase
  endfunction

  // Select the byte of the current message that is next in line
  always_comb begin
    cur_byte = 8'h0A;
    case (byte_idx_q[1:0])
      2'd0:    cur_byte = side_ascii(msg_side_q);
      2'd1:    cur_byte = hex_ascii(msg_price_q[7:4]);
      2'd2:    cur_byte = hex_ascii(msg_price_q[3:0]);
      default: cur_byte = 8'h0A;
    endcase
  end

  // Sequencer next state: pop on message start, feed bytes as the bit engine frees up
  always_comb begin
    msg_state_d = msg_state_q;
    byte_idx_d  = byte_idx_q;
    msg_side_d  = msg_side_q;
    msg_price_d = msg_price_q;
    fifo_pop    = 1'b0;
    tx_load     = 1'b0;
    case (msg_state_q)
      MSG_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop    = 1'b1;
          msg_side_d  = fifo_head[9:8];
          msg_price_d = fifo_head[7:0];
          byte_idx_d  = 3'd0;
          msg_state_d = MSG_SEND;
        end
      end
      default: begin
        if (tx_free) begin
          if (!byte_idx_q[2]) begin
            tx_load    = 1'b1;
            byte_idx_d = byte_idx_q + 3'd1;
          end else if (!fifo_empty) begin
            // Byte 3 just finished and more work is queued: start the next message
            fifo_pop    = 1'b1;
            msg_side_d  = fifo_head[9:8];
            msg_price_d = fifo_head[7:0];
            byte_idx_d  = 3'd0;
          end else begin
            msg_state_d = MSG_IDLE;
          end
        end
      end
    endcase
  end

  // Sequencer state registers
  always_ff @(posedge clk) begin
    if (rst) begin
      msg_state_q <= MSG_IDLE;
      byte_idx_q  <= 3'd0;
      msg_side_q  <= 2'b00;
      msg_price_q <= 8'h00;
    end else begin
      msg_state_q <= msg_state_d;
      byte_idx_q  <= byte_idx_d;
      msg_side_q  <= msg_side_d;
      msg_price_q <= msg_price_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Bit engine
  // ---------------------------------------------------------------------------
  logic [1:0]       tx_state_q, tx_state_d;
  logic [BaudW-1:0] baud_q, baud_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       tx_byte_q, tx_byte_d;
  logic             tx_q, tx_d;
  logic             baud_last;
  logic [2:0]       bit_idx_nxt;

  assign baud_last   = (baud_q == BaudLast);
  assign bit_idx_nxt = bit_idx_q + 3'd1;
  // Free during the last stop-bit cycle too, so the next start bit follows with no gap.
  assign tx_free     = (tx_state_q == TX_IDLE) || ((tx_state_q == TX_STOP) && baud_last);

  // Bit engine next state: start, 8 data bits LSB first, stop, each CLKS_PER_BIT wide
  always_comb begin
    tx_state_d = tx_state_q;
    baud_d     = baud_q;
    bit_idx_d  = bit_idx_q;
    tx_byte_d  = tx_byte_q;
    tx_d       = tx_q;
    case (tx_state_q)
      TX_IDLE: begin
        tx_d = 1'b1;
        if (tx_load) begin
          tx_state_d = TX_START;
          tx_byte_d  = cur_byte;
          baud_d     = '0;
          tx_d       = 1'b0;
        end
      end
      TX_START: begin
        if (baud_last) begin
          baud_d     = '0;
          bit_idx_d  = 3'd0;
          tx_state_d = TX_DATA;
          tx_d       = tx_byte_q[0];
        end else begin
          baud_d = baud_q + BaudW'(1);
        end
      end
      TX_DATA: begin
        if (baud_last) begin
          baud_d = '0;
          if (bit_idx_q == 3'd7) begin
            tx_state_d = TX_STOP;
            tx_d       = 1'b1;
          end else begin
            bit_idx_d = bit_idx_nxt;
            tx_d      = tx_byte_q[bit_idx_nxt];
          end
        end else begin
          baud_d = baud_q + BaudW'(1);
        end
      end
      default: begin
        if (baud_last) begin
          baud_d = '0;
          if (tx_load) begin
            tx_state_d = TX_START;
            tx_byte_d  = cur_byte;
            tx_d       = 1'b0;
          end else begin
            tx_state_d = TX_IDLE;
            tx_d       = 1'b1;
          end
        end else begin
          baud_d = baud_q + BaudW'(1);
        end
      end
    endcase
  end

  // Bit engine state registers; tx is driven straight from a flop
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_state_q <= TX_IDLE;
      baud_q     <= '0;
      bit_idx_q  <= 3'd0;
      tx_byte_q  <= 8'h00;
      tx_q       <= 1'b1;
    end else begin
      tx_state_q <= tx_state_d;
      baud_q     <= baud_d;
      bit_idx_q  <= bit_idx_d;
      tx_byte_q  <= tx_byte_d;
      tx_q       <= tx_d;
    end
  end

  assign tx       = tx_q;
  assign overflow = overflow_q;
  assign busy     = !fifo_empty || (msg_state_q != MSG_IDLE) || (tx_state_q != TX_IDLE);

endmodule
